// File: rtl/vie_sram_pkg.sv
// Shared definitions for the SRAM-like responder: size codes, LFSR constants
// and the packed layout of one pending response entry.
package vie_sram_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          LATENCY_MAX = 15;
  localparam int          AGE_W       = 4;

  typedef struct packed {
    logic             is_read;
    logic [31:0]      data;
    logic [AGE_W-1:0] age;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vie_resp_fifo.sv
// In-order response queue: circular buffer of pending entries with per-entry
// age counters; read data arrives one cycle after the push via the fill port.
module vie_resp_fifo
  import vie_sram_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        push_is_read,
  input  logic        fill_en,
  input  logic [31:0] fill_data,
  input  logic        pop,
  output logic        head_ready,
  output logic        full,
  output logic [31:0] head_data,
  output logic        head_is_read
);

  localparam int               PW      = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY_MAX);
  localparam logic [AGE_W-1:0] AGE_RDY = AGE_W'(LATENCY);

  logic [ENTRY_W-1:0] ent_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW-1:0]      fill_ptr_q, fill_ptr_d;
  logic [PW:0]        count_q, count_d;
  entry_t             head_ent;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_ptr_d = fill_ptr_q;
    count_d    = count_q;
    if (push) begin
      tail_d     = tail_q + 1'b1;
      fill_ptr_d = tail_q;
    end
    if (pop) head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
    end
  end

  // Stale slots keep aging harmlessly; count gates whether the head is looked at.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && tail_q == PW'(i)) begin
        ent_q[i] <= {push_is_read, 32'h0, AGE_W'(1)};
      end else begin
        if (fill_en && fill_ptr_q == PW'(i)) ent_q[i][AGE_W +: 32] <= fill_data;
        if (ent_q[i][AGE_W-1:0] != AGE_MAX)
          ent_q[i][AGE_W-1:0] <= ent_q[i][AGE_W-1:0] + 1'b1;
      end
    end
  end

  assign head_ent     = entry_t'(ent_q[head_q]);
  assign head_ready   = (count_q != '0) && (head_ent.age >= AGE_RDY);
  assign full         = (count_q == (PW+1)'(DEPTH));
  assign head_is_read = head_ent.is_read;
  // A LATENCY=1 read retires in the same cycle its data is being filled.
  assign head_data    = (fill_en && fill_ptr_q == head_q) ? fill_data : head_ent.data;

endmodule

// File: rtl/vie_sram_resp.sv
// SRAM-like responder backing one CPU port. Optional random stalls on accept
// and retire are built when VIE_SRAM_RAND_DELAY_EN is defined.
module vie_sram_resp
  import vie_sram_pkg::*;
#(
  parameter int AW          = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                           ((LATENCY < 1) ? 1 : LATENCY);

  logic [AW-1:0] idx;
  logic          accept, pop;
  logic          open_q, fill_q;
  logic [31:0]   rd_word;
  logic          head_ready, full, head_is_read;
  logic [31:0]   head_data;
  logic          acc_gate, ret_gate;
  logic          unused_bits;

  assign idx         = addr[AW+1:2];
  assign accept      = req & addr_ok;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [2**AW];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (accept && wr && wstrb[gi]) mem_q[idx] <= wdata[8*gi +: 8];
        if (accept && !wr)             rd_q       <= mem_q[idx];
      end
      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // open_q holds acceptance off for the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      open_q <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      open_q <= 1'b1;
      fill_q <= accept & ~wr;
    end
  end

`ifdef VIE_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_step(lfsr_q);
  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
  assign acc_gate = lfsr_q[0];
  assign ret_gate = lfsr_q[1];
`else
  assign acc_gate = 1'b1;
  assign ret_gate = 1'b1;
`endif

  assign addr_ok = resetn & open_q & ~full & acc_gate;
  assign pop     = resetn & head_ready & ret_gate;
  assign data_ok = pop;
  assign rdata   = (pop & head_is_read) ? head_data : 32'h0;

  vie_resp_fifo #(
    .DEPTH   (OUTSTANDING),
    .LATENCY (LAT_EFF)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (accept),
    .push_is_read (~wr),
    .fill_en      (fill_q),
    .fill_data    (rd_word),
    .pop          (pop),
    .head_ready   (head_ready),
    .full         (full),
    .head_data    (head_data),
    .head_is_read (head_is_read)
  );

endmodule
